// File: rtl/lfsr_prng_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_prng_pkg
//  Purpose  : Shared constants for the LFSR pseudo-random generator:
//             feedback mode selectors and default maximal polynomials.
//  Revision : 1.0 - initial release
// ============================================================================
package lfsr_prng_pkg;

    // Feedback topology selectors
    localparam int LFSR_FIB = 0;
    localparam int LFSR_GAL = 1;

    // Fibonacci tap masks: fb = ^(state & POLY), shifted in at bit 0
    localparam logic [3:0]  FIB_POLY_4  = 4'hC;
    localparam logic [7:0]  FIB_POLY_8  = 8'hB8;
    localparam logic [15:0] FIB_POLY_16 = 16'hB400;
    localparam logic [31:0] FIB_POLY_32 = 32'h8020_0003;

    // Galois masks: low-order coefficients of the primitive polynomial,
    // XORed in whenever the bit shifted out of the top is set
    localparam logic [3:0]  GAL_POLY_4  = 4'h3;
    localparam logic [7:0]  GAL_POLY_8  = 8'h1D;
    localparam logic [15:0] GAL_POLY_16 = 16'h100B;
    localparam logic [31:0] GAL_POLY_32 = 32'h0040_0007;

endpackage
`default_nettype wire

// File: rtl/lfsr_prng_if.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_prng_if
//  Purpose  : Control and output handshake bundle of the LFSR generator.
//             master = generator side, slave = controller/consumer side.
//  Revision : 1.0 - initial release
// ============================================================================
interface lfsr_prng_if #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] initial_num;
    logic [OUT_W-1:0] dout;
    logic             out_valid;
    logic             out_ready;
    logic             wrap;
    logic             seed_err;
    logic             lockup;

    modport master (
        input  en, load, initial_num, out_ready,
        output dout, out_valid, wrap, seed_err, lockup
    );

    modport slave (
        output en, load, initial_num, out_ready,
        input  dout, out_valid, wrap, seed_err, lockup
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_prng_step.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_prng_step
//  Purpose  : Purely combinational single LFSR shift (Fibonacci or Galois).
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr_prng_step
    import lfsr_prng_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(16'hB400),
    parameter int               MODE  = LFSR_FIB
) (
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] state_out
);

    generate
        if (MODE == LFSR_FIB) begin : g_fib
            // Parity of the tapped bits enters at the bottom
            logic w_fb;
            assign w_fb      = ^(state_in & POLY);
            assign state_out = {state_in[WIDTH-2:0], w_fb};
        end else begin : g_gal
            // Bit leaving the top folds the polynomial back in
            assign state_out = {state_in[WIDTH-2:0], 1'b0}
                             ^ (state_in[WIDTH-1] ? POLY : '0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/lfsr_prng.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_prng
//  Purpose  : Parametrised LFSR word generator with valid/ready output
//             register, zero-seed / lock-up protection and period-wrap flag.
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr_prng
    import lfsr_prng_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] POLY       = WIDTH'(16'hB400),
    parameter int               MODE       = LFSR_FIB,
    parameter int               STEPS      = 1,
    parameter int               OUT_W      = 8,
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
    input  logic            clk,
    input  logic            rst_n,
    lfsr_prng_if.master     bus
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_ref_seed;
    logic [OUT_W-1:0] r_dout;
    logic             r_out_valid;
    logic             r_wrap;
    logic             r_seed_err;
    logic             r_lockup;

    // STEPS single-shift stages chained combinationally
    logic [WIDTH-1:0] w_chain [0:STEPS];
    assign w_chain[0] = r_state;

    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
            lfsr_prng_step #(
                .WIDTH (WIDTH),
                .POLY  (POLY),
                .MODE  (MODE)
            ) u_step (
                .state_in  (w_chain[gi]),
                .state_out (w_chain[gi+1])
            );
        end
    endgenerate

    logic [WIDTH-1:0] w_nstate;
    logic             w_nstate_zero;
    logic [WIDTH-1:0] w_next_state;
    logic             w_seed_zero;
    logic [WIDTH-1:0] w_seed;
    logic             w_fire;
    logic             w_adv;

    assign w_nstate      = w_chain[STEPS];
    assign w_nstate_zero = (w_nstate == '0);
    // An all-zero state would stick forever, so restart from the reset seed
    assign w_next_state  = w_nstate_zero ? RESET_SEED : w_nstate;
    assign w_seed_zero   = (bus.initial_num == '0);
    assign w_seed        = w_seed_zero ? RESET_SEED : bus.initial_num;
    assign w_fire        = r_out_valid & bus.out_ready;
    // Advance only when the output register is empty or being drained
    assign w_adv         = bus.en & ~bus.load & (~r_out_valid | bus.out_ready);

    // Load has priority over advance, which has priority over plain consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RESET_SEED;
            r_ref_seed  <= RESET_SEED;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
            r_seed_err  <= 1'b0;
            r_lockup    <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_seed_err <= 1'b0;
            r_lockup   <= 1'b0;
            if (bus.load) begin
                r_state     <= w_seed;
                r_ref_seed  <= w_seed;
                r_seed_err  <= w_seed_zero;
                r_out_valid <= 1'b0;
            end else if (w_adv) begin
                r_state     <= w_next_state;
                r_lockup    <= w_nstate_zero;
                r_dout      <= w_next_state[OUT_W-1:0];
                r_out_valid <= 1'b1;
                r_wrap      <= (w_next_state == r_ref_seed);
            end else if (w_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.dout      = r_dout;
    assign bus.out_valid = r_out_valid;
    assign bus.wrap      = r_wrap;
    assign bus.seed_err  = r_seed_err;
    assign bus.lockup    = r_lockup;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prng.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_prng
//  Purpose  : Self-checking bench: directed 4-bit sequences, back-pressure,
//             zero seed, lock-up, async reset, and a randomized 16-bit
//             Galois / 3-step run against a polynomial-arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_prng;
    import lfsr_prng_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    lfsr_prng_if #(.WIDTH(4),  .OUT_W(4)) if_a ();
    lfsr_prng_if #(.WIDTH(4),  .OUT_W(4)) if_b ();
    lfsr_prng_if #(.WIDTH(4),  .OUT_W(4)) if_c ();
    lfsr_prng_if #(.WIDTH(16), .OUT_W(8)) if_d ();

    lfsr_prng #(.WIDTH(4), .POLY(4'hC), .MODE(LFSR_FIB), .STEPS(1), .OUT_W(4),
                .RESET_SEED(4'h1))
        u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    lfsr_prng #(.WIDTH(4), .POLY(4'h3), .MODE(LFSR_GAL), .STEPS(1), .OUT_W(4),
                .RESET_SEED(4'h1))
        u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    lfsr_prng #(.WIDTH(4), .POLY(4'h2), .MODE(LFSR_FIB), .STEPS(1), .OUT_W(4),
                .RESET_SEED(4'h1))
        u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
    lfsr_prng #(.WIDTH(16), .POLY(16'h100B), .MODE(LFSR_GAL), .STEPS(3), .OUT_W(8),
                .RESET_SEED(16'h0001))
        u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

    logic [3:0] fib_seq [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    logic [3:0] gal_seq [15] = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
                                 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input logic ld, input logic [3:0] num, input logic e, input logic rdy);
        if_a.load = ld; if_a.initial_num = num; if_a.en = e; if_a.out_ready = rdy;
        if_b.load = ld; if_b.initial_num = num; if_b.en = e; if_b.out_ready = rdy;
    endtask

    // Multiply by x modulo x^16 + x^12 + x^3 + x + 1
    function automatic logic [15:0] gal_mulx(input logic [15:0] s);
        int unsigned v;
        v = 32'(s) * 2;
        if (v >= 65536) v = (v - 65536) ^ 32'h100B;
        return 16'(v);
    endfunction

    // Reference model state for the randomized run
    logic [15:0] m_state, m_ref, m_ns, r_num;
    logic [7:0]  m_dout;
    logic        m_valid, m_wrap, m_seed_err, m_lockup;
    logic        r_ld, r_en, r_rdy, m_fire, m_adv;

    initial begin
        rst_n = 1'b0;
        set_ab(1'b0, 4'h0, 1'b0, 1'b0);
        if_c.load = 1'b0; if_c.initial_num = 4'h0; if_c.en = 1'b0; if_c.out_ready = 1'b0;
        if_d.load = 1'b0; if_d.initial_num = 16'h0; if_d.en = 1'b0; if_d.out_ready = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_dout",     32'(if_a.dout), 0);
        chk("rst_valid",    32'(if_a.out_valid), 0);
        chk("rst_wrap",     32'(if_a.wrap), 0);
        chk("rst_seed_err", 32'(if_a.seed_err), 0);
        chk("rst_lockup",   32'(if_a.lockup), 0);
        chk("rst_d_valid",  32'(if_d.out_valid), 0);
        rst_n = 1'b1;
        tick();

        // Full period, Fibonacci (a) and Galois (b) side by side
        set_ab(1'b1, 4'h1, 1'b0, 1'b1);
        tick();
        chk("load_valid", 32'(if_a.out_valid), 0);
        chk("load_serr",  32'(if_a.seed_err), 0);
        set_ab(1'b0, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("fib_dout",  32'(if_a.dout), 32'(fib_seq[i]));
            chk("fib_valid", 32'(if_a.out_valid), 1);
            chk("fib_wrap",  32'(if_a.wrap), 32'(i == 14));
            chk("gal_dout",  32'(if_b.dout), 32'(gal_seq[i]));
            chk("gal_wrap",  32'(if_b.wrap), 32'(i == 14));
        end
        tick();
        chk("fib_again", 32'(if_a.dout), 2);
        chk("fib_again_wrap", 32'(if_a.wrap), 0);
        chk("gal_again", 32'(if_b.dout), 2);

        // Back-pressure: first word must stay frozen while ready is low
        set_ab(1'b1, 4'h1, 1'b1, 1'b1);
        tick();
        set_ab(1'b0, 4'h0, 1'b1, 1'b1);
        tick();
        chk("bp_first", 32'(if_a.dout), 2);
        set_ab(1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_dout",  32'(if_a.dout), 2);
            chk("bp_hold_valid", 32'(if_a.out_valid), 1);
        end
        set_ab(1'b0, 4'h0, 1'b1, 1'b1);
        tick();
        chk("bp_release", 32'(if_a.dout), 4);

        // Consume without advance: valid drops, dout keeps its value
        set_ab(1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        chk("drain_valid", 32'(if_a.out_valid), 0);
        chk("drain_dout",  32'(if_a.dout), 4);
        set_ab(1'b0, 4'h0, 1'b1, 1'b1);
        tick();
        chk("resume_dout", 32'(if_a.dout), 9);

        // Zero seed load while a word is pending and being consumed
        set_ab(1'b1, 4'h0, 1'b1, 1'b1);
        tick();
        chk("zs_serr",  32'(if_a.seed_err), 1);
        chk("zs_valid", 32'(if_a.out_valid), 0);
        set_ab(1'b0, 4'h0, 1'b1, 1'b1);
        tick();
        chk("zs_serr_clr", 32'(if_a.seed_err), 0);
        chk("zs_word1",    32'(if_a.dout), 2);
        tick();
        chk("zs_word2",    32'(if_a.dout), 4);

        // Lock-up: tap only bit1, seed 8 steps to zero
        if_c.load = 1'b1; if_c.initial_num = 4'h8; if_c.en = 1'b0; if_c.out_ready = 1'b1;
        tick();
        chk("lk_serr", 32'(if_c.seed_err), 0);
        if_c.load = 1'b0; if_c.en = 1'b1;
        tick();
        chk("lk_pulse", 32'(if_c.lockup), 1);
        chk("lk_dout",  32'(if_c.dout), 1);
        chk("lk_valid", 32'(if_c.out_valid), 1);
        tick();
        chk("lk_clear", 32'(if_c.lockup), 0);
        chk("lk_next",  32'(if_c.dout), 2);

        // Asynchronous reset mid-run, released before the next edge
        chk("pre_rst_valid", 32'(if_a.out_valid), 1);
        rst_n = 1'b0;
        #2;
        chk("arst_valid", 32'(if_a.out_valid), 0);
        chk("arst_dout",  32'(if_a.dout), 0);
        chk("arst_wrap",  32'(if_a.wrap), 0);
        chk("arst_serr",  32'(if_a.seed_err), 0);
        chk("arst_c_valid", 32'(if_c.out_valid), 0);
        chk("arst_c_dout",  32'(if_c.dout), 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_word", 32'(if_a.dout), 2);
        chk("post_rst_valid", 32'(if_a.out_valid), 1);

        // Randomized run on the 16-bit Galois, 3-step instance
        m_state = 16'h0001; m_ref = 16'h0001; m_dout = 8'h00; m_valid = 1'b0;
        m_wrap = 1'b0; m_seed_err = 1'b0; m_lockup = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r_ld  = ($urandom_range(0, 15) == 0);
            r_num = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            r_en  = ($urandom_range(0, 3) != 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            if_d.load = r_ld; if_d.initial_num = r_num; if_d.en = r_en; if_d.out_ready = r_rdy;

            m_fire = m_valid & r_rdy;
            m_adv  = r_en & ~r_ld & (~m_valid | r_rdy);
            m_wrap = 1'b0; m_seed_err = 1'b0; m_lockup = 1'b0;
            if (r_ld) begin
                m_state    = (r_num == 0) ? 16'h0001 : r_num;
                m_ref      = m_state;
                m_seed_err = (r_num == 0);
                m_valid    = 1'b0;
            end else if (m_adv) begin
                m_ns = m_state;
                for (int k = 0; k < 3; k++) m_ns = gal_mulx(m_ns);
                if (m_ns == 0) begin
                    m_ns     = 16'h0001;
                    m_lockup = 1'b1;
                end
                m_state = m_ns;
                m_dout  = m_ns[7:0];
                m_valid = 1'b1;
                m_wrap  = (m_ns == m_ref);
            end else if (m_fire) begin
                m_valid = 1'b0;
            end

            tick();
            chk("rnd_dout",   32'(if_d.dout), 32'(m_dout));
            chk("rnd_valid",  32'(if_d.out_valid), 32'(m_valid));
            chk("rnd_wrap",   32'(if_d.wrap), 32'(m_wrap));
            chk("rnd_serr",   32'(if_d.seed_err), 32'(m_seed_err));
            chk("rnd_lockup", 32'(if_d.lockup), 32'(m_lockup));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
